// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for async_fifo.
// Functions work on GRAY_MAX_W bits; callers zero-extend and truncate to their pointer width.
package async_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int GRAY_MAX_W     = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, WIDTH bits wide, async active-low reset.
// Inputs must change at most one bit per source cycle (e.g. Gray-coded pointers).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignments so both stages
  // sample their inputs from before the edge; blocking here would collapse them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer-ready FIFO on a single clock. Define ASYNC_FIFO_SYNC_EN to cross
// the pointers through two-flop synchronisers and compare them in Gray code.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  push, pop;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers alone makes every
  // entry unreadable, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

`ifdef ASYNC_FIFO_SYNC_EN
  // Gray full pattern: top two bits inverted, the rest equal.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

  logic [PTR_W-1:0] wr_gray, rd_gray;
  logic [PTR_W-1:0] wr_gray_rs, rd_gray_ws;

  assign wr_gray = PTR_W'(bin2gray(GRAY_MAX_W'(wr_ptr_q)));
  assign rd_gray = PTR_W'(bin2gray(GRAY_MAX_W'(rd_ptr_q)));

  sync_2ff #(.WIDTH(PTR_W)) u_sync_wr2rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (wr_gray),
    .q_o   (wr_gray_rs)
  );

  sync_2ff #(.WIDTH(PTR_W)) u_sync_rd2wr (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rd_gray),
    .q_o   (rd_gray_ws)
  );

  assign empty = (rd_gray == wr_gray_rs);
  assign full  = (wr_gray == (rd_gray_ws ^ FULL_MASK));
`else
  localparam logic [PTR_W-1:0] WRAP_BIT = PTR_W'(1) << ADDR_WIDTH;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (wr_ptr_q == (rd_ptr_q ^ WRAP_BIT));
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed + randomized bench for async_fifo (default build), checked against a
// queue-based reference model of FIFO behaviour.
module tb_async_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic          full;
  logic          empty;
  logic [DW-1:0] rd_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_rd;

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply request, let the model decide acceptance, then compare all outputs.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
    bit push_ok, pop_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    push_ok = we && (model_q.size() < DEPTH);
    pop_ok  = re && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (pop_ok)  exp_rd = model_q.pop_front();
    if (push_ok) model_q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_word("rd_data", rd_data, exp_rd);
    check_bit("empty", empty, model_q.size() == 0);
    check_bit("full", full, model_q.size() == DEPTH);
  endtask

  initial begin
    int budget;
    logic [DW-1:0] r;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    exp_rd  = '0;

    // Reset state
    #30;
    check_bit("reset_empty", empty, 1'b1);
    check_bit("reset_full", full, 1'b0);
    check_word("reset_rd_data", rd_data, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // Basic ordering with idle gaps
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0001, 1'b0);
    cycle(1'b0, '0, 1'b0);
    budget = 0;
    while (empty !== 1'b0 && budget < 8) begin
      cycle(1'b0, '0, 1'b0);
      budget++;
    end
    check_bit("wait_not_empty", empty, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_word("basic_pop0", rd_data, 16'h1234);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_word("basic_pop1", rd_data, 16'h0000);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_word("basic_pop2", rd_data, 16'h0001);
    check_bit("basic_empty_end", empty, 1'b1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    check_bit("fill_full", full, 1'b1);
    cycle(1'b1, 16'hFFFF, 1'b0);
    check_bit("overflow_full", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      check_word("drain_order", rd_data, DW'(i));
    end
    check_bit("drain_empty", empty, 1'b1);

    // Underflow: rd_data must hold the last popped word
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    check_word("underflow_hold", rd_data, DW'(DEPTH - 1));
    cycle(1'b1, 16'hBEEF, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_word("after_underflow", rd_data, 16'hBEEF);

    // Streaming across pointer wrap with concurrent push and pop
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(i), 1'b1);
    cycle(1'b0, '0, 1'b1);
    check_word("stream_last", rd_data, DW'(39));

    // Random traffic: write-biased phase then read-biased phase
    for (int i = 0; i < 300; i++) begin
      r = DW'($urandom);
      if (i < 150) cycle($urandom_range(0, 99) < 70, r, $urandom_range(0, 99) < 30);
      else         cycle($urandom_range(0, 99) < 30, r, $urandom_range(0, 99) < 70);
    end
    while (model_q.size() != 0) cycle(1'b0, '0, 1'b1);

    // Mid-operation reset, asserted between edges
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_empty", empty, 1'b1);
    check_bit("midrst_full", full, 1'b0);
    check_word("midrst_rd_data", rd_data, 16'h0000);
    model_q.delete();
    exp_rd = '0;
    #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1);
    check_word("midrst_pop_nothing", rd_data, 16'h0000);
    cycle(1'b1, 16'hA5A5, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_word("midrst_recover", rd_data, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
# async_fifo

Single-clock, parameterised first-in/first-out buffer. It decouples a producer and a consumer running on the same clock domain. Internally it is built with Gray-coded pointers so that it can later be split into a true dual-clock FIFO without restructuring. It sits between a streaming data source and its consumer; both sides share `clk` and `rst_n`.

## Interface
- `DATA_WIDTH`, default 16: width of each stored word.
- `ADDR_WIDTH`, default 4: storage address width; depth `DEPTH = 2**ADDR_WIDTH` (16 words).

Ports:
- `clk`  input  1  single clock for write and read sides, rising-edge active.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `wr_data`  input  DATA_WIDTH  word to push.
- `wr_en`  input  1  push request, sampled on rising `clk`.
- `full`  output  1  no free entry; pushes are ignored.
- `rd_en`  input  1  pop request, sampled on rising `clk`.
- `rd_data`  output  DATA_WIDTH  registered popped word.
- `empty`  output  1  no readable entry; pops are ignored.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. It is not reset.
- Pointers: write and read pointers are ADDR_WIDTH+1 bits wide, binary. The low ADDR_WIDTH bits address the array. The MSB is a wrap bit, so the pointers wrap naturally modulo 2*DEPTH.
- Push: on a rising edge with `wr_en && !full`, write `wr_data` to mem[wr_ptr] and increment wr_ptr.
- Pop: on a rising edge with `rd_en && !empty`, load `rd_data <= mem[rd_ptr]` and increment rd_ptr.
- `rd_data` holds its last value whenever no pop occurs.
- Overflow: `wr_en` while `full` is dropped silently. Nothing changes.
- Underflow: `rd_en` while `empty` is dropped silently. `rd_data` and the pointers are unchanged.
- Simultaneous push and pop are legal. Each side is qualified independently by its own flag value at that edge.
- Flags:
  - `empty` is set when the read pointer equals the write pointer as seen by the read side.
  - `full` is set when the pointers differ only in the MSB, using the read pointer as seen by the write side.
  - Both flags are derived from registered state only, with no combinational path from `wr_en`/`rd_en`.
- Reset (asserting `rst_n` low): asynchronously clears the pointers, any synchroniser flops and `rd_data` (set to 0), and forces `empty`=1, `full`=0. Reset asserted mid-operation discards all stored words.

## Timing
- Write-to-readable latency:
  - Without the macro: `empty` falls right after the write edge (same cycle).
  - With the macro: `empty` falls 2 edges later.
- Read latency: `rd_data` is valid immediately after the rising edge that pops (1 edge after `rd_en` is sampled high).
- Pop-to-not-full latency: 0 extra edges without the macro, 2 extra edges with it. While the flag lags, it stays conservative: it still reads full or empty.
- Deasserting `rst_n` is synchronous to `clk`. The first push may occur on the first rising edge after release.

## Configuration
- `ASYNC_FIFO_SYNC_EN`:
  - Defined: pointers are converted to Gray code and crossed through two-flop synchronisers, write→read for `empty` and read→write for `full`. The comparisons are then made in Gray code.
  - Undefined: flags are computed directly from the local binary pointers, with no added latency.
- Data path and ordering are identical in both builds.

## Structure
- Package `async_fifo_pkg` holds:
  - default width constants (`DEF_DATA_WIDTH`=16, `DEF_ADDR_WIDTH`=4);
  - functions `bin2gray` and `gray2bin`, parameterised by width through the caller.
- Sub-module `sync_2ff`: a WIDTH-parameterised two-flop synchroniser with async active-low reset. It is instantiated twice, only when `ASYNC_FIFO_SYNC_EN` is defined.

## Test plan
- Reset: hold `rst_n`=0 for 30 ns → `empty`=1, `full`=0, `rd_data`=0x0000. The flags stay this way after release with no traffic.
- Basic order: push 0x1234, 0x0000, 0x0001 as single-cycle pulses separated by idle cycles. Wait until `empty`=0, then pop three times with idle cycles between → `rd_data` is 0x1234, 0x0000, 0x0001, each valid right after its pop edge. `empty`=1 after the third pop.
- Fill/overflow: push 0..15 → `full`=1 (after flag latency). Push 0xFFFF → ignored. Drain → 0..15 in order, never 0xFFFF, and `empty`=1 at the end.
- Underflow: `rd_en`=1 for 3 cycles while empty → `rd_data` holds its previous value, `empty` stays 1, and a later push/pop of 0xBEEF returns 0xBEEF.
- Wrap/streaming: 40 words 0..39 with `wr_en` and `rd_en` both high concurrently → output sequence 0..39 with no loss or duplication across pointer wrap. `full` never asserts.
- Mid-operation reset: store 5 words, pulse `rst_n` low between edges → `empty`=1 and `full`=0 immediately (before the next edge). A following pop returns nothing and `rd_data`=0x0000.
